// File: rtl/iir_sched_pkg.sv
// Shared types and constants for the IIR cascade scheduler.
// Holds the scheduler state enum and the coefficient reset values.
package iir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } sched_state_e;

    localparam logic [31:0] COEF_A_RST = 32'h4000_0000;
    localparam logic [31:0] COEF_B_RST = 32'hc77f_fc00;

endpackage

// File: rtl/iir_coef_bank.sv
// Shadow/active coefficient storage for the time-multiplexed sections.
// Ports: clk, rst_n; shadow write (we, waddr, wdata_a/b); copy strobe;
// combinational read of the active bank (raddr -> rdata_a/b).
module iir_coef_bank
    import iir_sched_pkg::*;
#(
    parameter int NUM_SECTIONS = 4,
    parameter int AW           = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata_a,
    input  logic [31:0]   wdata_b,
    input  logic          copy,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata_a,
    output logic [31:0]   rdata_b
);

    logic [31:0] sh_a_q  [NUM_SECTIONS];
    logic [31:0] sh_b_q  [NUM_SECTIONS];
    logic [31:0] act_a_q [NUM_SECTIONS];
    logic [31:0] act_b_q [NUM_SECTIONS];
    logic [31:0] sh_a_d  [NUM_SECTIONS];
    logic [31:0] sh_b_d  [NUM_SECTIONS];
    logic [31:0] act_a_d [NUM_SECTIONS];
    logic [31:0] act_b_d [NUM_SECTIONS];

    // The copy reads the registered shadow, so a same-cycle write
    // lands in the shadow only and is not part of this commit.
    always_comb begin
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        act_a_d = act_a_q;
        act_b_d = act_b_q;
        if (copy) begin
            act_a_d = sh_a_q;
            act_b_d = sh_b_q;
        end
        if (we && (int'(waddr) < NUM_SECTIONS)) begin
            sh_a_d[waddr] = wdata_a;
            sh_b_d[waddr] = wdata_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                sh_a_q[i]  <= COEF_A_RST;
                sh_b_q[i]  <= COEF_B_RST;
                act_a_q[i] <= COEF_A_RST;
                act_b_q[i] <= COEF_B_RST;
            end
        end else begin
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            act_a_q <= act_a_d;
            act_b_q <= act_b_d;
        end
    end

    assign rdata_a = act_a_q[raddr];
    assign rdata_b = act_b_q[raddr];

endmodule

// File: rtl/iir_cascade_scheduler.sv
// Schedules NUM_SECTIONS cascaded IIR sections onto one shared section.
// Ports: s_* sample in, m_* sample out, cfg_* coefficient load/commit,
// sec_* shared-section launch/operands/result, busy status.
module iir_cascade_scheduler
    import iir_sched_pkg::*;
#(
    parameter int WORD_LENGTH_X   = 23,
    parameter int NUM_SECTIONS    = 4,
    parameter int SECTION_LATENCY = 3,
    localparam int W  = WORD_LENGTH_X + 8,
    localparam int AW = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_coef_a,
    input  logic [31:0]   cfg_coef_b,
    input  logic          cfg_commit,
    output logic          sec_start,
    output logic [W-1:0]  sec_x,
    output logic [31:0]   sec_coef_a,
    output logic [31:0]   sec_coef_b,
    input  logic [W-1:0]  sec_y,
    output logic          busy
);

    localparam int CW = (SECTION_LATENCY > 1) ? $clog2(SECTION_LATENCY) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SECTIONS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SECTION_LATENCY - 1);

    sched_state_e  state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  work_q, work_d;
    logic          pend_q, pend_d;
    logic          armed_q, armed_d;
    logic          accept, last_wait, copy_fire;

    assign accept    = s_valid && s_ready;
    assign last_wait = (state_q == WAIT) && (cnt_q == LAST_CNT);

    // Commit waits for an idle cycle with no accept so that the
    // active bank never changes while a sample is in flight.
    assign copy_fire = (pend_q || cfg_commit) && (state_q == IDLE) && !accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (last_wait) state_d = (idx_q == LAST_IDX) ? DONE : LAUNCH;
            DONE:    if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = (state_q == IDLE) && armed_q;
        busy      = (state_q != IDLE);
        sec_start = (state_q == LAUNCH);
        m_valid   = (state_q == DONE);
        m_data    = (state_q == DONE) ? work_q : '0;
        sec_x     = work_q;
    end

    always_comb begin
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        armed_d = 1'b1;
        pend_d  = (pend_q || cfg_commit) && !copy_fire;
        if (accept) begin
            work_d = s_data;
            idx_d  = '0;
        end
        if (state_q == LAUNCH) cnt_d = '0;
        if (state_q == WAIT)   cnt_d = cnt_q + CW'(1);
        if (last_wait) begin
            work_d = sec_y;
            if (idx_q != LAST_IDX) idx_d = idx_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            pend_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
        end
    end

    iir_coef_bank #(
        .NUM_SECTIONS (NUM_SECTIONS),
        .AW           (AW)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_we),
        .waddr   (cfg_addr),
        .wdata_a (cfg_coef_a),
        .wdata_b (cfg_coef_b),
        .copy    (copy_fire),
        .raddr   (idx_q),
        .rdata_a (sec_coef_a),
        .rdata_b (sec_coef_b)
    );

endmodule
